// File: rtl/sdram_ioctl_loader.sv
// Streams ioctl download bytes into SDRAM port C, one write per byte; first weC rise 2 clocks after a strobe.
// busy at FIFO count >= FIFO_DEPTH-2, full-FIFO strobes are dropped (sticky overflow); SDRAM_LOADER_CHKSUM_EN adds checksum.
module sdram_ioctl_loader #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [24:0] BASE_ADDR  = 25'h0,
  parameter int          GAP_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        busy,
  output logic        overflow,
  output logic        done,
  output logic [24:0] addrC,
  output logic [7:0]  dinC,
  output logic        weC,
  output logic        oeC,
`ifdef SDRAM_LOADER_CHKSUM_EN
  output logic [15:0] checksum,
`endif
  input  logic        ackC
);

  localparam int AW         = $clog2(FIFO_DEPTH);
  localparam int GW         = $clog2(GAP_CYCLES + 1);
  localparam int BUSY_I     = FIFO_DEPTH - 2;
  localparam int GAP_LAST_I = GAP_CYCLES - 1;

  localparam logic [AW:0]   DEPTH_C  = FIFO_DEPTH[AW:0];
  localparam logic [AW:0]   BUSY_LVL = BUSY_I[AW:0];
  localparam logic [GW-1:0] GAP_LAST = GAP_LAST_I[GW-1:0];

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP
  } state_t;

  state_t state_q, state_d;

  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          push, pop;
  logic [24:0]   entry_addr;

  logic          ack_last;
  logic [GW-1:0] gap_cnt;
  logic          download_q;
  logic          dl_rise, dl_fall;
  logic          pend_done;

  assign empty      = (count == '0);
  assign busy       = (count >= BUSY_LVL);
  assign entry_addr = BASE_ADDR + ioctl_addr;
  assign dl_rise    = ioctl_download & ~download_q;
  assign dl_fall    = ~ioctl_download & download_q;

  // A pop in the same cycle frees a slot, so a strobe into a full FIFO still lands.
  assign push = ioctl_wr & ((count < DEPTH_C) | pop);

  assign weC = (state_q == ISSUE);
  assign oeC = 1'b0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {entry_addr, ioctl_dout};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end else if (!ioctl_download && pend_done) begin
          done = 1'b1;
        end
      end
      ISSUE: begin
        // The controller acknowledges by toggling, not by level.
        if (ackC != ack_last) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrC      <= '0;
      dinC       <= '0;
      ack_last   <= 1'b0;
      gap_cnt    <= '0;
      download_q <= 1'b0;
      pend_done  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      // Tracking ackC while idle keeps us in phase after a reset mid-write.
      if (state_q == IDLE) begin
        ack_last <= ackC;
      end
      if (pop) begin
        {addrC, dinC} <= mem[rd_ptr];
      end
      gap_cnt    <= (state_q == GAP) ? gap_cnt + 1'b1 : '0;
      download_q <= ioctl_download;

      if (dl_rise) begin
        pend_done <= 1'b0;
      end else if (dl_fall) begin
        pend_done <= 1'b1;
      end else if (done) begin
        pend_done <= 1'b0;
      end

      if (dl_rise) begin
        overflow <= 1'b0;
      end
      if (ioctl_wr && !push) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef SDRAM_LOADER_CHKSUM_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      checksum <= '0;
    end else if (dl_rise) begin
      checksum <= '0;
    end else if (state_q == ISSUE && ackC != ack_last) begin
      checksum <= checksum + {8'h00, dinC};
    end
  end
`endif

endmodule
